// File: rtl/cardinal_nic.sv
// Network interface between a PE and one router port: a one-entry eject buffer
// and a one-entry inject buffer, reached by the PE through a 2-bit register map.
module cardinal_nic #(
  parameter int PACKET_SIZE = 64
) (
  input  logic                   clk,
  input  logic                   reset,
  input  logic [1:0]             addr,
  input  logic [PACKET_SIZE-1:0] d_in,
  output logic [PACKET_SIZE-1:0] d_out,
  input  logic                   nicEn,
  input  logic                   nicEnWr,
  input  logic                   net_si,
  output logic                   net_ri,
  input  logic [PACKET_SIZE-1:0] net_di,
  output logic                   net_so,
  input  logic                   net_ro,
  output logic [PACKET_SIZE-1:0] net_do,
  input  logic                   net_polarity
);

  localparam logic [1:0] ADDR_IN_BUF     = 2'b00;
  localparam logic [1:0] ADDR_IN_STATUS  = 2'b01;
  localparam logic [1:0] ADDR_OUT_BUF    = 2'b10;
  localparam logic [1:0] ADDR_OUT_STATUS = 2'b11;

  logic [PACKET_SIZE-1:0] in_buf_q, in_buf_d;
  logic                   in_full_q, in_full_d;
  logic [PACKET_SIZE-1:0] out_buf_q, out_buf_d;
  logic                   out_full_q, out_full_d;

  logic rd_en, wr_en;
  logic eject_take, in_pop, out_push;

  // Handshakes: a packet moves across a channel on a posedge where its valid
  // and ready are both high; neither side may retract valid data on its own.
  assign rd_en      = nicEn & ~nicEnWr;
  assign wr_en      = nicEn & nicEnWr;
  assign net_ri     = reset & ~in_full_q;
  assign eject_take = net_si & net_ri;
  assign in_pop     = rd_en & (addr == ADDR_IN_BUF) & in_full_q;
  assign out_push   = wr_en & (addr == ADDR_OUT_BUF) & ~out_full_q;

  // The VC bit must match the ring polarity of the current cycle to inject.
  assign net_so = reset & out_full_q & net_ro
                  & (out_buf_q[PACKET_SIZE-1] == net_polarity);
  assign net_do = out_full_q ? out_buf_q : '0;

  always_comb begin
    in_buf_d   = in_buf_q;
    in_full_d  = in_full_q;
    out_buf_d  = out_buf_q;
    out_full_d = out_full_q;
    if (eject_take) begin
      in_buf_d  = net_di;
      in_full_d = 1'b1;
    end else if (in_pop) begin
      in_full_d = 1'b0;
    end
    // A write landing while the buffer is still full is dropped, even if the
    // packet leaves on this same edge.
    if (net_so) begin
      out_full_d = 1'b0;
    end else if (out_push) begin
      out_buf_d  = d_in;
      out_full_d = 1'b1;
    end
  end

  always_comb begin
    d_out = '0;
    if (reset && rd_en) begin
      case (addr)
        ADDR_IN_BUF:     d_out = in_buf_q;
        ADDR_IN_STATUS:  d_out = {{(PACKET_SIZE-1){1'b0}}, in_full_q};
        ADDR_OUT_BUF:    d_out = out_buf_q;
        ADDR_OUT_STATUS: d_out = {{(PACKET_SIZE-1){1'b0}}, out_full_q};
        default:         d_out = '0;
      endcase
    end
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      in_buf_q   <= '0;
      in_full_q  <= 1'b0;
      out_buf_q  <= '0;
      out_full_q <= 1'b0;
    end else begin
      in_buf_q   <= in_buf_d;
      in_full_q  <= in_full_d;
      out_buf_q  <= out_buf_d;
      out_full_q <= out_full_d;
    end
  end

endmodule

// File: tb/tb_cardinal_nic.sv
// Directed bench for cardinal_nic: PE reads and router injections are checked
// by a negedge monitor against expected queues filled by the stimulus.
module tb_cardinal_nic;

  localparam int W = 64;

  logic         clk;
  logic         reset;
  logic [1:0]   addr;
  logic [W-1:0] d_in;
  logic [W-1:0] d_out;
  logic         nicEn;
  logic         nicEnWr;
  logic         net_si;
  logic         net_ri;
  logic [W-1:0] net_di;
  logic         net_so;
  logic         net_ro;
  logic [W-1:0] net_do;
  logic         net_polarity;

  logic [W-1:0] exp_q[$];
  logic [1:0]   exp_addr_q[$];
  logic [W-1:0] inj_q[$];

  int n_cmp = 0;
  int n_bad = 0;

  cardinal_nic #(.PACKET_SIZE(W)) dut (
    .clk(clk), .reset(reset), .addr(addr), .d_in(d_in), .d_out(d_out),
    .nicEn(nicEn), .nicEnWr(nicEnWr), .net_si(net_si), .net_ri(net_ri),
    .net_di(net_di), .net_so(net_so), .net_ro(net_ro), .net_do(net_do),
    .net_polarity(net_polarity)
  );

  // ---------------- clock / reset / ring polarity ----------------
  initial clk = 1'b0;
  always #5 clk = ~clk;

  always @(posedge clk or negedge reset) begin
    if (!reset) net_polarity <= 1'b0;
    else        net_polarity <= ~net_polarity;
  end

  initial begin
    #100000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  // ---------------- checking ----------------
  task automatic chk(input string name, input logic [W-1:0] act, input logic [W-1:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %h, expected %h", name, act, exp);
    end
  endtask

  always @(negedge clk) begin
    logic [W-1:0] e;
    logic [1:0]   a;
    if (reset === 1'b1) begin
      if (nicEn && !nicEnWr) begin
        if (exp_q.size() == 0) begin
          chk("rd_unexpected", {62'd0, addr}, '1);
        end else begin
          e = exp_q.pop_front();
          a = exp_addr_q.pop_front();
          chk($sformatf("rd_addr%0d", a), d_out, e);
        end
      end
      if (net_so) begin
        if (inj_q.size() == 0) begin
          chk("inj_unexpected", net_do, '1);
        end else begin
          e = inj_q.pop_front();
          chk("inj_data", net_do, e);
          chk("inj_vc_match", {63'd0, net_polarity}, {63'd0, e[W-1]});
        end
      end
    end
  end

  // ---------------- driver tasks (called at posedge+1) ----------------
  task automatic next_cycle();
    @(posedge clk);
    #1;
  endtask

  task automatic pe_read(input logic [1:0] a, input logic [W-1:0] exp);
    exp_q.push_back(exp);
    exp_addr_q.push_back(a);
    nicEn = 1'b1; nicEnWr = 1'b0; addr = a;
    next_cycle();
    nicEn = 1'b0;
  endtask

  task automatic pe_write(input logic [1:0] a, input logic [W-1:0] data);
    nicEn = 1'b1; nicEnWr = 1'b1; addr = a; d_in = data;
    next_cycle();
    nicEn = 1'b0; nicEnWr = 1'b0;
  endtask

  task automatic eject(input logic [W-1:0] data);
    net_si = 1'b1; net_di = data;
    next_cycle();
    net_si = 1'b0;
  endtask

  task automatic wait_even();
    for (int i = 0; i < 4 && net_polarity != 1'b0; i++) next_cycle();
  endtask

  task automatic drain_inject(input string name);
    for (int i = 0; i < 8 && inj_q.size() != 0; i++) next_cycle();
    chk(name, inj_q.size(), 0);
  endtask

  // ---------------- stimulus ----------------
  localparam logic [W-1:0] PKT_A = 64'h0123_4567_89AB_CDEF;
  localparam logic [W-1:0] PKT_X = 64'h8000_0000_0000_0055;
  localparam logic [W-1:0] PKT_Y = 64'h0000_0000_0000_1234;
  localparam logic [W-1:0] PKT_Z = 64'h8000_0000_0000_00AA;
  localparam logic [W-1:0] PKT_J = 64'hDEAD_BEEF_DEAD_BEEF;

  initial begin
    logic [W-1:0] pkt_b, pkt_c, pkt_d, pkt_e;
    reset = 1'b0; addr = 2'b00; d_in = '0; nicEn = 1'b0; nicEnWr = 1'b0;
    net_si = 1'b0; net_di = '0; net_ro = 1'b0;

    // 1: reset values, then release
    repeat (3) next_cycle();
    chk("rst_net_ri", net_ri, 0);
    chk("rst_net_so", net_so, 0);
    chk("rst_d_out", d_out, 0);
    chk("rst_net_do", net_do, 0);
    @(negedge clk) reset = 1'b1;
    next_cycle();
    chk("post_rst_net_ri", net_ri, 1);
    chk("post_rst_net_so", net_so, 0);
    pe_read(2'b01, 0);
    pe_read(2'b11, 0);

    // 2: eject, status, read-out frees the buffer
    eject(PKT_A);
    chk("eject_full_net_ri", net_ri, 0);
    pe_read(2'b01, 1);
    pe_read(2'b00, PKT_A);
    pe_read(2'b01, 0);
    chk("eject_freed_net_ri", net_ri, 1);
    // ignored writes and stale read of an empty in-buf
    pe_write(2'b00, PKT_J);
    pe_write(2'b01, PKT_J);
    pe_write(2'b11, PKT_J);
    pe_read(2'b00, PKT_A);
    pe_read(2'b01, 0);
    pe_read(2'b11, 0);

    // 3: inject on a matching odd cycle, then one that must wait
    net_ro = 1'b1;
    wait_even();
    inj_q.push_back(PKT_X);
    pe_write(2'b10, PKT_X);
    chk("inj_x_so_polarity1", net_so, 1);
    drain_inject("inj_x_drain");
    pe_read(2'b11, 0);
    wait_even();
    inj_q.push_back(PKT_Y);
    pe_write(2'b10, PKT_Y);
    chk("inj_y_so_mismatch", net_so, 0);
    drain_inject("inj_y_drain");

    // 4: router not ready for 5 cycles; held packet, dropped second write
    net_ro = 1'b0;
    inj_q.push_back(PKT_Z);
    pe_write(2'b10, PKT_Z);
    for (int i = 0; i < 5; i++) begin
      chk("hold_net_so", net_so, 0);
      chk("hold_net_do", net_do, PKT_Z);
      next_cycle();
    end
    pe_write(2'b10, PKT_J);
    pe_read(2'b10, PKT_Z);
    pe_read(2'b11, 1);
    net_ro = 1'b1;
    drain_inject("inj_z_drain");
    pe_read(2'b11, 0);

    // 5: second eject while full is refused
    pkt_b = 64'h1111_2222_3333_4444;
    pkt_c = 64'h5555_6666_7777_8888;
    eject(pkt_b);
    chk("full_net_ri", net_ri, 0);
    eject(pkt_c);
    pe_read(2'b00, pkt_b);
    pe_read(2'b01, 0);
    // read and eject in the same cycle: no capture
    pkt_d = 64'h0000_FFFF_0000_FFFF;
    pkt_e = 64'hAAAA_5555_AAAA_5555;
    eject(pkt_d);
    net_si = 1'b1; net_di = pkt_e;
    pe_read(2'b00, pkt_d);
    net_si = 1'b0;
    chk("simul_net_ri", net_ri, 1);
    pe_read(2'b01, 0);
    pe_read(2'b00, pkt_d);

    // 6: reset while both buffers are full
    net_ro = 1'b0;
    eject(PKT_A);
    pe_write(2'b10, PKT_X);
    pe_read(2'b01, 1);
    pe_read(2'b11, 1);
    #1;
    reset = 1'b0;
    nicEn = 1'b1; nicEnWr = 1'b0; addr = 2'b10;
    net_ro = 1'b1;
    #1;
    chk("midrst_net_so", net_so, 0);
    chk("midrst_net_ri", net_ri, 0);
    chk("midrst_d_out", d_out, 0);
    chk("midrst_net_do", net_do, 0);
    next_cycle();
    nicEn = 1'b0;
    net_ro = 1'b0;
    reset = 1'b1;
    next_cycle();
    chk("after_rst_net_ri", net_ri, 1);
    pe_read(2'b01, 0);
    pe_read(2'b11, 0);

    next_cycle();
    chk("rd_queue_empty", exp_q.size(), 0);
    chk("inj_queue_empty", inj_q.size(), 0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
